// File: rtl/accu_pkg.sv
// Shared constants and sizing helper for the group accumulator and its consumers.
package accu_pkg;

    localparam int ACCU_DATA_W  = 8;
    localparam int ACCU_GROUP_N = 4;

    // Full-precision sum width: a group of group_n max-value samples never overflows it.
    function automatic int sum_w(input int data_w, input int group_n);
        return data_w + $clog2(group_n);
    endfunction

endpackage

// File: rtl/accu_out_slot.sv
// Single-entry output register with valid/ready handshake and upstream ready derivation.
module accu_out_slot
    import accu_pkg::*;
#(
    parameter int SUM_W = 10,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SUM_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             ready_out,
    output logic             ready_in,
    output logic             valid_out,
    output logic [SUM_W-1:0] data_out,
    output logic [CNT_W-1:0] count_out
);

    // Handshake: a transfer happens on an edge where valid && ready are both high.
    // The slot can take a new result whenever it is empty or its result leaves on
    // the same edge, so consumption and the next load may coincide.
    assign ready_in = !valid_out || ready_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            count_out <= '0;
        end else if (load) begin
            valid_out <= 1'b1;
            data_out  <= load_data;
            count_out <= load_count;
        end else if (valid_out && ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: rtl/accu_group.sv
// Serial accumulator: sums GROUP_N accepted samples (or a flushed partial group)
// and emits one result per group, optionally averaged for full groups.
module accu_group
    import accu_pkg::*;
#(
    parameter int DATA_W  = ACCU_DATA_W,
    parameter int GROUP_N = ACCU_GROUP_N
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic                              flush,
    input  logic                              avg_mode,
    output logic [sum_w(DATA_W, GROUP_N)-1:0] data_out,
    output logic [$clog2(GROUP_N):0]          count_out,
    output logic                              valid_out,
    input  logic                              ready_out
);

    localparam int LOG2_N = $clog2(GROUP_N);
    localparam int CNT_W  = LOG2_N + 1;
    localparam int SUM_W  = sum_w(DATA_W, GROUP_N);

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             beat;
    logic             close;
    logic [CNT_W-1:0] samples;
    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] result;

    assign beat    = valid_in && ready_in;
    assign samples = cnt + {{(CNT_W-1){1'b0}}, beat};
    assign total   = acc + (beat ? {{(SUM_W-DATA_W){1'b0}}, data_in} : '0);

    // A flush that lands on the natural full-group beat yields one full group.
    assign close = (beat && cnt == CNT_W'(GROUP_N - 1))
                || (flush && ready_in && (cnt != '0 || beat));

    // Partial groups always report the raw sum; only full groups may be averaged.
    assign result = (avg_mode && samples == CNT_W'(GROUP_N)) ? (total >> LOG2_N) : total;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (close) begin
            acc <= '0;
            cnt <= '0;
        end else if (beat) begin
            acc <= total;
            cnt <= samples;
        end
    end

    accu_out_slot #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_out_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (close),
        .load_data  (result),
        .load_count (samples),
        .ready_out  (ready_out),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .count_out  (count_out)
    );

endmodule

// File: tb/tb_accu_group.sv
// Directed bench for accu_group (DATA_W=8, GROUP_N=4) with hand-computed expectations.
module tb_accu_group;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        ready_in;
    logic        flush;
    logic        avg_mode;
    logic [9:0]  data_out;
    logic [2:0]  count_out;
    logic        valid_out;
    logic        ready_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accu_group #(
        .DATA_W  (8),
        .GROUP_N (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .flush     (flush),
        .avg_mode  (avg_mode),
        .data_out  (data_out),
        .count_out (count_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    // Advance one rising edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [9:0] d,
                             input logic [2:0] c);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".data"},  {22'd0, data_out},  {22'd0, d});
        check({tag, ".count"}, {29'd0, count_out}, {29'd0, c});
    endtask

    task automatic beat(input logic [7:0] d);
        valid_in = 1'b1;
        data_in  = d;
        tick();
    endtask

    initial begin
        logic [7:0] vec3 [4];
        vec3 = '{8'd10, 8'd20, 8'd30, 8'd41};

        rst = 1'b1; data_in = '0; valid_in = 1'b0; flush = 1'b0;
        avg_mode = 1'b0; ready_out = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_out("reset", 1'b0, 10'd0, 3'd0);
        check("reset.ready_in", {31'd0, ready_in}, 32'd1);

        // 1: 1,2,3,4 -> 10, one-cycle valid pulse
        beat(8'd1); beat(8'd2); beat(8'd3);
        check("t1.no_early_valid", {31'd0, valid_out}, 32'd0);
        beat(8'd4);
        check_out("t1.result", 1'b1, 10'd10, 3'd4);
        valid_in = 1'b0;
        tick();
        check_out("t1.consumed", 1'b0, 10'd10, 3'd4);

        // 2: two streamed groups of 255 -> 1020 each, input never stalls
        for (int i = 0; i < 8; i++) begin
            beat(8'd255);
            check($sformatf("t2.ready_in%0d", i), {31'd0, ready_in}, 32'd1);
            if (i == 3 || i == 7) check_out($sformatf("t2.result%0d", i), 1'b1, 10'd1020, 3'd4);
            else                  check($sformatf("t2.idle%0d", i), {31'd0, valid_out}, 32'd0);
        end
        valid_in = 1'b0;
        tick();

        // flush on every beat: consume and next close share an edge
        flush = 1'b1;
        beat(8'd3);
        check_out("fl1.first", 1'b1, 10'd3, 3'd1);
        beat(8'd6);
        check_out("fl1.second", 1'b1, 10'd6, 3'd1);
        flush = 1'b0; valid_in = 1'b0;
        tick();
        check("fl1.drained", {31'd0, valid_out}, 32'd0);

        // flush coinciding with full-group close: one full output
        beat(8'd1); beat(8'd1); beat(8'd1);
        flush = 1'b1;
        beat(8'd1);
        check_out("flfull.result", 1'b1, 10'd4, 3'd4);
        flush = 1'b0; valid_in = 1'b0;
        tick();
        check("flfull.single", {31'd0, valid_out}, 32'd0);

        // 3: avg mode, 101 >> 2 = 25
        avg_mode = 1'b1;
        for (int i = 0; i < 4; i++) beat(vec3[i]);
        check_out("t3.avg", 1'b1, 10'd25, 3'd4);
        valid_in = 1'b0; avg_mode = 1'b0;
        tick();

        // 4: backpressure hold
        ready_out = 1'b0;
        beat(8'd1); beat(8'd1); beat(8'd1); beat(8'd1);
        check_out("t4.closed", 1'b1, 10'd4, 3'd4);
        for (int i = 0; i < 5; i++) begin
            beat(8'd7);
            check_out($sformatf("t4.hold%0d", i), 1'b1, 10'd4, 3'd4);
            check($sformatf("t4.stall%0d", i), {31'd0, ready_in}, 32'd0);
        end
        ready_out = 1'b1;
        #1;
        check("t4.ready_comb", {31'd0, ready_in}, 32'd1);
        beat(8'd7);
        check("t4.released", {31'd0, valid_out}, 32'd0);
        beat(8'd7); beat(8'd7); beat(8'd7);
        check_out("t4.resumed", 1'b1, 10'd28, 3'd4);
        valid_in = 1'b0;
        tick();

        // 5: partial flush reports raw sum even with avg_mode
        avg_mode = 1'b1;
        beat(8'd5); beat(8'd7);
        valid_in = 1'b0; flush = 1'b1;
        tick();
        check_out("t5.partial", 1'b1, 10'd12, 3'd2);
        tick();
        check_out("t5.empty_flush", 1'b0, 10'd12, 3'd2);
        flush = 1'b0; avg_mode = 1'b0;

        // 6: reset mid-group clears state and outputs
        beat(8'd9); beat(8'd9); beat(8'd9);
        valid_in = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("t6.reset", 1'b0, 10'd0, 3'd0);
        beat(8'd1); beat(8'd1); beat(8'd1); beat(8'd1);
        check_out("t6.no_residue", 1'b1, 10'd4, 3'd4);
        valid_in = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
